spi_exec_sequencer: RTL and testbench

SPI-facing instruction sequencer for the super simple SPI CPU. It deserialises 8-bit instruction frames from the host, then drives the 4-bit opcode into the instruction decoder and strobes execution. It expands the loop opcodes into multi-cycle shift/add sequences. While a frame is being received, it returns an accumulator snapshot on MISO.

---
 rtl/spi_cpu_pkg.sv | 41 ++++
 rtl/spi_frame_rx.sv | 93 +++++++++
 rtl/spi_exec_sequencer.sv | 126 ++++++++++++
 tb/tb_spi_exec_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cpu_pkg.sv
// Shared definitions for the super simple SPI CPU: opcode map, sequencer
// state encoding and small decode helpers.
package spi_cpu_pkg;

    typedef enum logic [3:0] {
        OP_LDA  = 4'd0,
        OP_LDI  = 4'd1,
        OP_STA  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_LSH  = 4'd5,
        OP_RSH  = 4'd6,
        OP_CLR  = 4'd7,
        OP_SNZA = 4'd8,
        OP_SNZS = 4'd9,
        OP_ADD  = 4'd10,
        OP_SUB  = 4'd11,
        OP_XOR  = 4'd12,
        OP_INC  = 4'd13,
        OP_DEC  = 4'd14,
        OP_INV  = 4'd15
    } opcode_e;

    // Sequencer state encoding, kept as plain constants for legacy netlists.
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_LOOP_ADD   = 2'd2;
    localparam logic [1:0] ST_LOOP_SHIFT = 2'd3;

    localparam int unsigned FRAME_W = 8;

    // Loop opcodes expand into N add/shift pairs instead of a single strobe.
    function automatic logic is_loop_op(input logic [3:0] op);
        return (op == OP_SNZA) || (op == OP_SNZS);
    endfunction

    function automatic logic is_clr_op(input logic [3:0] op);
        return op == OP_CLR;
    endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises the host pins, deserialises 8-bit
// frames on MOSI and returns the accumulator snapshot on MISO.
module spi_frame_rx
    import spi_cpu_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 CLKin,
    input  logic                 RST,
    input  logic                 SCLK,
    input  logic                 CS_N,
    input  logic                 MOSI,
    input  logic [FRAME_W-1:0]   ACCout,
    output logic                 MISO,
    output logic                 frame_valid,
    output logic [FRAME_W-1:0]   frame
);

    // SYNC_STAGES must be at least 2 for the shift below.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;

    logic [2:0]             bit_cnt;
    // rx keeps only the bits still needed; the full byte is formed at completion.
    logic [FRAME_W-2:0]     rx;
    // tx holds the bits not yet presented; MISO itself carries the current bit.
    logic [FRAME_W-2:0]     tx;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    always_ff @(posedge CLKin) begin
        if (RST) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            mosi_sync   <= '0;
            sclk_prev   <= 1'b0;
            cs_prev     <= 1'b1;
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            MISO        <= 1'b0;
            frame_valid <= 1'b0;
            frame       <= '0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], CS_N};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_prev   <= sclk_s;
            cs_prev     <= cs_s;
            frame_valid <= 1'b0;

            if (cs_fall) begin
                bit_cnt <= '0;
                tx      <= ACCout[FRAME_W-2:0];
                MISO    <= ACCout[FRAME_W-1];
            end else if (cs_s) begin
                // Deselect abandons any partial frame.
                bit_cnt <= '0;
            end else begin
                if (sclk_rise) begin
                    rx <= {rx[FRAME_W-3:0], mosi_s};
                    if (bit_cnt == 3'd7) begin
                        frame_valid <= 1'b1;
                        frame       <= {rx, mosi_s};
                        bit_cnt     <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                if (sclk_fall) begin
                    MISO <= tx[FRAME_W-2];
                    tx   <= {tx[FRAME_W-3:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_exec_sequencer.sv
// Instruction sequencer: issues received SPI frames to the decoder and
// expands SNZA/SNZS into alternating add/shift strobes.
module spi_exec_sequencer
    import spi_cpu_pkg::*;
#(
    parameter int unsigned COUNT_W     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         CLKin,
    input  logic         RST,
    input  logic         SCLK,
    input  logic         CS_N,
    input  logic         MOSI,
    output logic         MISO,
    input  logic [7:0]   ACCout,
    input  logic         SF,
    output logic [3:0]   opcode,
    output logic         exec_en,
    output logic         busy,
    output logic         overrun
);

    logic               frame_valid;
    logic [7:0]         frame;

    logic [1:0]         state_q;
    logic [3:0]         op_q;
    logic [COUNT_W-1:0] n_q;
    logic [COUNT_W-1:0] count_q;
    logic [3:0]         op_hold_q;
    logic               overrun_q;
    logic [3:0]         op_cur;

    // SF only matters to the datapath; it is brought in for debug probing.
    logic               sf_unused;
    assign sf_unused = SF;

    spi_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_frame_rx (
        .CLKin       (CLKin),
        .RST         (RST),
        .SCLK        (SCLK),
        .CS_N        (CS_N),
        .MOSI        (MOSI),
        .ACCout      (ACCout),
        .MISO        (MISO),
        .frame_valid (frame_valid),
        .frame       (frame)
    );

    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;
    assign opcode  = op_cur;

    always_comb begin
        exec_en = 1'b0;
        op_cur  = op_hold_q;
        case (state_q)
            ST_ISSUE: begin
                if (!is_loop_op(op_q)) begin
                    exec_en = 1'b1;
                    op_cur  = op_q;
                end
            end
            ST_LOOP_ADD: begin
                exec_en = 1'b1;
                op_cur  = op_q;
            end
            ST_LOOP_SHIFT: begin
                exec_en = 1'b1;
                op_cur  = OP_LSH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLKin) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            n_q       <= '0;
            count_q   <= '0;
            op_hold_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (exec_en) begin
                op_hold_q <= op_cur;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_valid) begin
                        op_q    <= frame[7:4];
                        n_q     <= COUNT_W'(frame[3:0]);
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (is_loop_op(op_q)) begin
                        count_q <= n_q;
                        state_q <= (n_q == '0) ? ST_IDLE : ST_LOOP_ADD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOOP_ADD: begin
                    state_q <= ST_LOOP_SHIFT;
                end
                ST_LOOP_SHIFT: begin
                    count_q <= count_q - COUNT_W'(1);
                    state_q <= (count_q == COUNT_W'(1)) ? ST_IDLE : ST_LOOP_ADD;
                end
                default: state_q <= ST_IDLE;
            endcase

            // A frame landing while busy is lost; that outranks a concurrent CLR.
            if (frame_valid && busy) begin
                overrun_q <= 1'b1;
            end else if (state_q == ST_ISSUE && is_clr_op(op_q)) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_exec_sequencer.sv
// Randomised scoreboard bench for spi_exec_sequencer: a frame-level model
// predicts the strobe stream, busy windows, MISO bytes and the overrun flag.
module tb_spi_exec_sequencer;

    logic       CLKin = 1'b0;
    logic       RST   = 1'b1;
    logic       SCLK  = 1'b0;
    logic       CS_N  = 1'b1;
    logic       MOSI  = 1'b0;
    logic       SF    = 1'b0;
    logic [7:0] ACCout = 8'h00;
    logic       MISO;
    logic [3:0] opcode;
    logic       exec_en;
    logic       busy;
    logic       overrun;

    spi_exec_sequencer #(
        .COUNT_W     (4),
        .SYNC_STAGES (2)
    ) dut (
        .CLKin   (CLKin),
        .RST     (RST),
        .SCLK    (SCLK),
        .CS_N    (CS_N),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .ACCout  (ACCout),
        .SF      (SF),
        .opcode  (opcode),
        .exec_en (exec_en),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 CLKin = ~CLKin;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [3:0]  exp_ops[$];
    int unsigned exp_busy[$];
    logic        model_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Frame-level model: plain ops give one strobe, loops give N (op,LSH) pairs.
    task automatic model_push(input logic [7:0] f);
        logic [3:0]  op;
        int unsigned nn;
        op = f[7:4];
        nn = 32'(f[3:0]);
        if (op == 4'd8 || op == 4'd9) begin
            for (int unsigned k = 0; k < nn; k++) begin
                exp_ops.push_back(op);
                exp_ops.push_back(4'd5);
            end
            exp_busy.push_back(2 * nn + 1);
        end else begin
            exp_ops.push_back(op);
            exp_busy.push_back(1);
            if (op == 4'd7) model_ovr = 1'b0;
        end
    endtask

    // Mode-0 host: MOSI set while SCLK low, MISO read at the end of the high phase.
    task automatic spi_xfer(input logic [7:0] data, input int unsigned nbits,
                            input int unsigned half, output logic [7:0] got);
        got = 8'h00;
        for (int unsigned i = 0; i < nbits; i++) begin
            MOSI = data[7-i];
            #(half);
            SCLK = 1'b1;
            #(half);
            got  = {got[6:0], MISO};
            SCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] f, input logic [7:0] acc);
        logic [7:0] got;
        @(negedge CLKin);
        #2;
        model_push(f);
        ACCout = acc;
        CS_N   = 1'b0;
        #80;
        ACCout = acc ^ 8'($urandom_range(1, 255));
        SF     = 1'($urandom);
        spi_xfer(f, 8, 40, got);
        #40;
        CS_N = 1'b1;
        check("miso_byte", 32'(got), 32'(acc));
        #400;
    endtask

    // Monitor: pops the expected opcode on every strobe and the expected
    // busy window length whenever busy drops.
    initial begin
        int unsigned run;
        run = 0;
        forever begin
            @(negedge CLKin);
            if (exec_en === 1'b1) begin
                if (exp_ops.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: opcode %0d, nothing expected", opcode);
                end else begin
                    check("opcode", 32'(opcode), 32'(exp_ops.pop_front()));
                end
            end
            if (busy === 1'b1) begin
                run++;
            end else if (run != 0) begin
                if (exp_busy.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_busy: %0d cycles, nothing expected", run);
                end else begin
                    check("busy_len", run, exp_busy.pop_front());
                end
                run = 0;
            end
        end
    end

    initial begin
        logic [7:0]  got;
        int unsigned seen;

        RST = 1'b1;
        repeat (4) @(negedge CLKin);
        check("rst_miso",    32'(MISO),    32'd0);
        check("rst_opcode",  32'(opcode),  32'd0);
        check("rst_exec_en", 32'(exec_en), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLKin);

        send_frame(8'hA0, 8'($urandom));
        send_frame(8'h93, 8'($urandom));
        send_frame(8'h80, 8'($urandom));
        send_frame(8'h21, 8'hB6);

        // Burst at SCLK = CLKin/3 with CS_N held low, so 0xA0 completes
        // well inside the 31-cycle busy window of 0x9F and must be dropped.
        @(negedge CLKin);
        #2;
        model_push(8'h9F);
        model_ovr = 1'b1;
        CS_N = 1'b0;
        #80;
        spi_xfer(8'h9F, 8, 15, got);
        spi_xfer(8'hA0, 8, 15, got);
        #40;
        CS_N = 1'b1;
        #500;
        check("overrun_set", 32'(overrun), 32'(model_ovr));

        send_frame(8'h70, 8'($urandom));
        check("overrun_clr", 32'(overrun), 32'(model_ovr));

        // Partial frame: five bits then deselect, nothing may issue.
        @(negedge CLKin);
        #2;
        CS_N = 1'b0;
        #80;
        spi_xfer(8'hE8, 5, 40, got);
        #40;
        CS_N = 1'b1;
        #400;
        send_frame(8'h10, 8'($urandom));

        for (int unsigned r = 0; r < 12; r++) begin
            send_frame(8'($urandom), 8'($urandom));
        end
        check("overrun_rand", 32'(overrun), 32'(model_ovr));

        // Reset during the add step of the second iteration of 0x94:
        // busy has then lasted ISSUE plus three steps.
        @(negedge CLKin);
        #2;
        model_push(8'h94);
        CS_N = 1'b0;
        #80;
        spi_xfer(8'h94, 7, 40, got);
        MOSI = 1'b0;
        #40;
        SCLK = 1'b1;
        seen = 0;
        for (int unsigned c = 0; c < 200 && seen < 3; c++) begin
            @(negedge CLKin);
            if (exec_en === 1'b1) seen++;
        end
        if (seen < 3) begin
            n_cmp++;
            n_bad++;
            $display("FAIL loop_timeout: saw %0d strobes, needed 3", seen);
        end else begin
            if (exp_busy.size() != 0) exp_busy[exp_busy.size()-1] = 4;
            RST = 1'b1;
            @(negedge CLKin);
            check("rst_loop_exec_en", 32'(exec_en), 32'd0);
            check("rst_loop_busy",    32'(busy),    32'd0);
            exp_ops.delete();
            model_ovr = 1'b0;
            RST = 1'b0;
        end
        #40;
        SCLK = 1'b0;
        CS_N = 1'b1;
        #400;
        check("rst_loop_overrun", 32'(overrun), 32'(model_ovr));
        send_frame(8'h35, 8'($urandom));

        #1000;
        check("leftover_ops",  32'(exp_ops.size()),  32'd0);
        check("leftover_busy", 32'(exp_busy.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
